mux_scan_ctrl: RTL and testbench

- Sequencer that sits around the 4:1 channel selector (`choose`).
- Upstream, it drives the selector's `addr` and active-high disable `N`, stepping through channels 0..3.
- Downstream, it samples the selector output `M` once per channel and assembles a 4-bit snapshot.
- It supports a single scan or continuous scanning, with a start/stop handshake and a one-cycle valid strobe per completed scan.

---
 rtl/mux_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer around the 4:1 channel selector: steps addr 0..3,
// dwells on each channel, captures M and publishes a 4-bit snapshot.
module mux_scan_ctrl #(
   parameter int DWELL = 2,
   parameter int CNT_W = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       mode,
   input  logic       stop,
   output logic [1:0] addr,
   output logic       N,
   input  logic       M,
   output logic [3:0] sample,
   output logic       valid,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [3:0]       shadow, shadow_nx;
   logic [3:0]       sample_nx;
   logic [1:0]       addr_nx;
   logic             n_nx;
   logic             valid_nx;
   logic             busy_nx;
   logic             stop_pend, stop_pend_nx;
   logic             mode_q, mode_nx;
   logic             last;

   assign last = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         shadow    <= '0;
         sample    <= '0;
         addr      <= '0;
         N         <= 1'b1;
         valid     <= 1'b0;
         busy      <= 1'b0;
         stop_pend <= 1'b0;
         mode_q    <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         shadow    <= shadow_nx;
         sample    <= sample_nx;
         addr      <= addr_nx;
         N         <= n_nx;
         valid     <= valid_nx;
         busy      <= busy_nx;
         stop_pend <= stop_pend_nx;
         mode_q    <= mode_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = SCAN;
         SCAN: if (last && addr == 2'd3) state_nx = DONE;
         DONE: begin
            if (mode_q && !stop_pend && !stop) state_nx = SCAN;
            else                               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      cnt_nx       = cnt;
      shadow_nx    = shadow;
      sample_nx    = sample;
      addr_nx      = addr;
      n_nx         = N;
      valid_nx     = 1'b0;
      stop_pend_nx = stop_pend;
      mode_nx      = mode_q;
      busy_nx      = (state_nx != IDLE);
      unique case (state)
         IDLE: begin
            n_nx    = 1'b1;
            addr_nx = 2'd0;
            if (start) begin
               mode_nx      = mode;
               stop_pend_nx = 1'b0;
               cnt_nx       = '0;
               n_nx         = 1'b0;
            end
         end
         SCAN: begin
            if (stop) stop_pend_nx = 1'b1;
            if (last) begin
               shadow_nx[addr] = M;
               cnt_nx          = '0;
               if (addr == 2'd3) begin
                  // bit 3 comes straight from M on the closing edge
                  sample_nx = shadow_nx;
                  valid_nx  = 1'b1;
                  n_nx      = 1'b1;
                  addr_nx   = 2'd0;
               end else begin
                  addr_nx = addr + 2'd1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         DONE: begin
            addr_nx = 2'd0;
            cnt_nx  = '0;
            if (mode_q && !stop_pend && !stop) begin
               n_nx = 1'b0;
            end else begin
               n_nx         = 1'b1;
               stop_pend_nx = 1'b0;
            end
         end
         default: begin
            n_nx    = 1'b1;
            addr_nx = 2'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (DWELL=2 and DWELL=1) share
// stimulus and are each checked against a scan-phase reference model.
module tb_mux_scan_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       mode;
   logic       stop;
   logic [3:0] a;

   logic [1:0] addr_w   [2];
   logic       n_w      [2];
   logic       m_w      [2];
   logic [3:0] sample_w [2];
   logic       valid_w  [2];
   logic       busy_w   [2];

   int n_chk;
   int n_fail;

   // reference model: t = position within the scan (0 = idle)
   int         t    [2];
   bit         cont [2];
   bit         sp   [2];
   logic [3:0] mbits[2];
   logic [3:0] msamp[2];
   int         dw   [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // the 4:1 selector the controller drives
   assign m_w[0] = n_w[0] ? 1'b0 : a[addr_w[0]];
   assign m_w[1] = n_w[1] ? 1'b0 : a[addr_w[1]];

   mux_scan_ctrl #(.DWELL(2), .CNT_W(4)) u_dut0 (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .mode   (mode),
      .stop   (stop),
      .addr   (addr_w[0]),
      .N      (n_w[0]),
      .M      (m_w[0]),
      .sample (sample_w[0]),
      .valid  (valid_w[0]),
      .busy   (busy_w[0])
   );

   mux_scan_ctrl #(.DWELL(1), .CNT_W(4)) u_dut1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .mode   (mode),
      .stop   (stop),
      .addr   (addr_w[1]),
      .N      (n_w[1]),
      .M      (m_w[1]),
      .sample (sample_w[1]),
      .valid  (valid_w[1]),
      .busy   (busy_w[1])
   );

   task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         t[i]     = 0;
         cont[i]  = 1'b0;
         sp[i]    = 1'b0;
         mbits[i] = 4'h0;
         msamp[i] = 4'h0;
      end
   endtask

   // advance the model by one clock edge using the current inputs
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         int d;
         int l;
         int k;
         d = dw[i];
         l = 4 * d;
         if (!rst_n) begin
            t[i]     = 0;
            sp[i]    = 1'b0;
            msamp[i] = 4'h0;
         end else if (t[i] == 0) begin
            if (start) begin
               t[i]    = 1;
               cont[i] = mode;
               sp[i]   = 1'b0;
            end
         end else if (t[i] <= l) begin
            if (stop) sp[i] = 1'b1;
            k = (t[i] - 1) / d;
            if (t[i] % d == 0) mbits[i][k] = a[k];
            if (t[i] == l) msamp[i] = mbits[i];
            t[i] = t[i] + 1;
         end else begin
            if (cont[i] && !sp[i] && !stop) t[i] = 1;
            else t[i] = 0;
            sp[i] = 1'b0;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         int   l;
         bit   sc;
         logic [3:0] ea;
         l  = 4 * dw[i];
         sc = (t[i] >= 1 && t[i] <= l);
         ea = sc ? 4'((t[i] - 1) / dw[i]) : 4'd0;
         chk($sformatf("addr[%0d] t=%0d", i, t[i]), {2'b00, addr_w[i]}, ea);
         chk($sformatf("N[%0d] t=%0d", i, t[i]), {3'b000, n_w[i]}, {3'b000, !sc});
         chk($sformatf("valid[%0d] t=%0d", i, t[i]), {3'b000, valid_w[i]},
             {3'b000, t[i] == l + 1});
         chk($sformatf("busy[%0d] t=%0d", i, t[i]), {3'b000, busy_w[i]},
             {3'b000, t[i] != 0});
         chk($sformatf("sample[%0d] t=%0d", i, t[i]), sample_w[i], msamp[i]);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      int vcnt;
      n_chk  = 0;
      n_fail = 0;
      dw[0]  = 2;
      dw[1]  = 1;
      rst_n  = 1'b0;
      start  = 1'b0;
      mode   = 1'b0;
      stop   = 1'b0;
      a      = 4'h0;
      model_reset();

      // reset and idle
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (10) tick();

      // single scan, pattern 1011
      a     = 4'b1011;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (11) tick();
      chk("single_sample", sample_w[0], 4'b1011);
      chk("single_idle", {3'b000, busy_w[0]}, 4'd0);

      // start while busy is ignored
      a     = 4'b0101;
      start = 1'b1;
      tick();
      start = 1'b0;
      vcnt  = 0;
      for (int c = 2; c <= 14; c++) begin
         start = (c == 3);
         tick();
         if (valid_w[0]) vcnt++;
      end
      start = 1'b0;
      chk("one_valid", 4'(vcnt), 4'd1);

      // continuous with stop during the second scan
      a     = 4'b1100;
      mode  = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      mode  = 1'b0;
      repeat (8) tick();
      chk("cont_first", sample_w[0], 4'b1100);
      a = 4'b0110;
      for (int c = 1; c <= 20; c++) begin
         stop = (c == 4);
         tick();
      end
      stop = 1'b0;
      chk("cont_second", sample_w[0], 4'b0110);
      chk("cont_stopped", {3'b000, busy_w[0]}, 4'd0);

      // asynchronous reset during channel 2
      a     = 4'b1111;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("async_sample", sample_w[0], 4'h0);
      chk("async_N", {3'b000, n_w[0]}, 4'd1);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (10) tick();

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         start = ($urandom % 6 == 0);
         mode  = $urandom % 2;
         stop  = ($urandom % 9 == 0);
         if ($urandom % 3 == 0) a = 4'($urandom);
         tick();
      end
      start = 1'b0;
      stop  = 1'b1;
      repeat (20) tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
